// File: rtl/q2_pkg.sv
// Shared definitions for the Q2 CPU micro-sequencer: state codes and sequencer modes.
package q2_pkg;

  localparam logic [3:0] ST_FETCH = 4'd0;
  localparam logic [3:0] ST_LOAD  = 4'd1;
  localparam logic [3:0] ST_DEREF = 4'd2;
  localparam logic [3:0] ST_EXEC  = 4'd3;
  localparam logic [3:0] ST_ALU0  = 4'd4;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STEP,
    MODE_PARKED,
    MODE_HALTED
  } mode_e;

  // Last ALU state code for a given number of bit-serial ALU steps.
  function automatic logic [3:0] alu_last_code(input int steps);
    return 4'(3 + steps);
  endfunction

endpackage

// File: rtl/q2_sequencer_if.sv
// Front-panel, decoder and state-code signals between the Q2 sequencer and its surroundings.
interface q2_sequencer_if;

  logic       run;
  logic       step_req;
  logic [4:0] dbus_op;
  logic       op1;
  logic       op2;
  logic       op3;
  logic       op4;
  logic       op5;
  logic       halt;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       s3;
  logic       ws;
  logic       running;
  logic       instr_done;

  modport master (
    output run, step_req, dbus_op, op1, op2, op3, op4, op5, halt,
    input  s0, s1, s2, s3, ws, running, instr_done
  );

  modport slave (
    input  run, step_req, dbus_op, op1, op2, op3, op4, op5, halt,
    output s0, s1, s2, s3, ws, running, instr_done
  );

endinterface

// File: rtl/q2_edge_detect.sv
// Synchronous rising-edge detector; o_rise is high in the cycle i_d is first seen high.
module q2_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/q2_sequencer.sv
// Q2 micro-state sequencer: two-clock micro-states (read phase, then write phase),
// with run/step/halt control applied only at instruction boundaries.
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int ALU_STEPS = 12
) (
  input logic           clk,
  input logic           rst,
  q2_sequencer_if.slave bus
);

  localparam logic [3:0] LP_ALU_LAST = alu_last_code(ALU_STEPS);

  mode_e      r_mode;
  logic [3:0] r_code;
  logic       r_ws;
  logic       r_running;
  logic       r_done;

  logic       w_run_rise;
  logic       w_step_rise;
  logic       w_start_run;
  logic       w_halt_now;
  logic       w_ends;
  logic [3:0] w_next_code;
  logic       w_unused;

  q2_edge_detect u_run_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.run),
    .o_rise (w_run_rise)
  );

  q2_edge_detect u_step_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.step_req),
    .o_rise (w_step_rise)
  );

  // A run level restarts from PARKED; from HALTED only a fresh run edge does.
  assign w_start_run = (r_mode == MODE_PARKED) ? bus.run : w_run_rise;
  assign w_halt_now  = (r_code == ST_EXEC) && bus.halt;

  always_comb begin
    w_next_code = ST_FETCH;
    w_ends      = 1'b0;
    case (r_code)
      ST_FETCH: begin
        if (bus.dbus_op[1]) begin
          w_next_code = ST_LOAD;
        end else if (bus.dbus_op[0]) begin
          w_next_code = ST_DEREF;
        end else begin
          w_next_code = ST_EXEC;
        end
      end
      ST_LOAD:  w_next_code = bus.op1 ? ST_DEREF : ST_EXEC;
      ST_DEREF: w_next_code = ST_EXEC;
      ST_EXEC: begin
        if (!bus.op5) begin
          w_next_code = ST_ALU0;
        end else begin
          w_ends = 1'b1;
        end
      end
      default: begin
        if (r_code < LP_ALU_LAST) begin
          w_next_code = r_code + 4'd1;
        end else begin
          w_ends = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= MODE_PARKED;
      r_code    <= ST_FETCH;
      r_ws      <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_mode)
        MODE_PARKED, MODE_HALTED: begin
          if (w_start_run) begin
            r_mode    <= MODE_RUN;
            r_running <= 1'b1;
            r_code    <= ST_FETCH;
            r_ws      <= 1'b0;
          end else if (w_step_rise) begin
            r_mode    <= MODE_STEP;
            r_running <= 1'b0;
            r_code    <= ST_FETCH;
            r_ws      <= 1'b0;
          end
        end
        default: begin
          if (!bus.run) begin
            r_running <= 1'b0;
          end
          if (!r_ws) begin
            r_ws <= 1'b1;
          end else begin
            r_ws <= 1'b0;
            if (w_halt_now) begin
              r_mode    <= MODE_HALTED;
              r_code    <= ST_EXEC;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else if (w_ends) begin
              r_done <= 1'b1;
              r_code <= ST_FETCH;
              // Single-step and a dropped run both land in PARKED here.
              if (!(r_running && bus.run)) begin
                r_mode    <= MODE_PARKED;
                r_running <= 1'b0;
              end
            end else begin
              r_code <= w_next_code;
            end
          end
        end
      endcase
    end
  end

  assign bus.s0         = r_code[0];
  assign bus.s1         = r_code[1];
  assign bus.s2         = r_code[2];
  assign bus.s3         = r_code[3];
  assign bus.ws         = r_ws;
  assign bus.running    = r_running;
  assign bus.instr_done = r_done;

  // Opcode bits the sequencer does not branch on.
  assign w_unused = ^{bus.op2, bus.op3, bus.op4, bus.dbus_op[4:2]};

endmodule
